// File: rtl/bist_sram_dp_if.sv
// bist_sram_dp_if: port bundle for the simple-dual-port BIST SRAM model
//   master drives: we/waddr/wdata (write port), re/raddr (read port),
//                  flt_we/flt_idx/flt_addr/flt_bit/flt_type/flt_en/flt_clr (fault table)
//   slave drives:  rdata (registered read data), rvalid (read accepted last cycle)
interface bist_sram_dp_if #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int NUM_FLT = 4
);
    localparam int IDX_W = NUM_FLT > 1 ? $clog2(NUM_FLT) : 1;
    localparam int BIT_W = DATA_W > 1 ? $clog2(DATA_W) : 1;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              flt_we;
    logic [IDX_W-1:0]  flt_idx;
    logic [ADDR_W-1:0] flt_addr;
    logic [BIT_W-1:0]  flt_bit;
    logic [1:0]        flt_type;
    logic              flt_en;
    logic              flt_clr;
    modport master (
        output we, waddr, wdata, re, raddr,
        output flt_we, flt_idx, flt_addr, flt_bit, flt_type, flt_en, flt_clr,
        input  rdata, rvalid
    );
    modport slave (
        input  we, waddr, wdata, re, raddr,
        input  flt_we, flt_idx, flt_addr, flt_bit, flt_type, flt_en, flt_clr,
        output rdata, rvalid
    );
endinterface

// File: rtl/bist_sram_dp.sv
// bist_sram_dp: simple-dual-port SRAM with programmable stuck-at/transition fault injection
//   clk  : sole clock
//   rst  : asynchronous active-high reset (clears read register and fault table, not the array)
//   bus  : slave side of bist_sram_dp_if (write port, read port, fault-table programming)
//   flt_type: 00 SA0, 01 SA1, 10 TF-up (no 0->1), 11 TF-down (no 1->0)
module bist_sram_dp #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int RDW_MODE = 0,
    parameter int NUM_FLT  = 4
) (
    input logic          clk,
    input logic          rst,
    bist_sram_dp_if.slave bus
);
    localparam int IDX_W = NUM_FLT > 1 ? $clog2(NUM_FLT) : 1;
    localparam int BIT_W = DATA_W > 1 ? $clog2(DATA_W) : 1;
    // one extra bit so a bit position >= DATA_W can be detected and ignored
    localparam logic [BIT_W:0] DW = DATA_W[BIT_W:0];
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [NUM_FLT-1:0] f_en;
    logic [ADDR_W-1:0]  f_addr [NUM_FLT];
    logic [BIT_W-1:0]   f_bit  [NUM_FLT];
    logic [1:0]         f_type [NUM_FLT];
    logic [DATA_W-1:0]  cur, wval, rraw, rval, rdata_q;
    logic               rvalid_q;
    assign cur = mem[bus.waddr];
    // Transition faults: later (higher-index) entries override earlier ones on the same bit.
    // An unknown stored bit makes the blocking condition unknown, so the write proceeds normally.
    always_comb begin
        wval = bus.wdata;
        for (int i = 0; i < NUM_FLT; i++)
            if (f_en[i] && f_type[i][1] && f_addr[i] == bus.waddr && {1'b0, f_bit[i]} < DW) begin
                if (f_type[i][0] ? (cur[f_bit[i]] && !bus.wdata[f_bit[i]])
                                 : (!cur[f_bit[i]] && bus.wdata[f_bit[i]]))
                    wval[f_bit[i]] = cur[f_bit[i]];
                else
                    wval[f_bit[i]] = bus.wdata[f_bit[i]];
            end
    end
    // Old-data mode falls out of reading the array before the write lands.
    assign rraw = (RDW_MODE == 0 && bus.we && bus.waddr == bus.raddr) ? wval : mem[bus.raddr];
    always_comb begin
        rval = rraw;
        for (int i = 0; i < NUM_FLT; i++)
            if (f_en[i] && !f_type[i][1] && f_addr[i] == bus.raddr && {1'b0, f_bit[i]} < DW)
                rval[f_bit[i]] = f_type[i][0];
    end
    always_ff @(posedge clk)
        if (bus.we)
            mem[bus.waddr] <= wval;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            f_en <= '0;
            for (int i = 0; i < NUM_FLT; i++) begin
                f_addr[i] <= '0;
                f_bit[i]  <= '0;
                f_type[i] <= '0;
            end
        end else if (bus.flt_clr)
            f_en <= '0;
        else if (bus.flt_we)
            for (int i = 0; i < NUM_FLT; i++)
                if (bus.flt_idx == i[IDX_W-1:0]) begin
                    f_en[i]   <= bus.flt_en;
                    f_addr[i] <= bus.flt_addr;
                    f_bit[i]  <= bus.flt_bit;
                    f_type[i] <= bus.flt_type;
                end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= bus.re;
            if (bus.re)
                rdata_q <= rval;
        end
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
endmodule

// File: tb/tb_bist_sram_dp.sv
// tb_bist_sram_dp: scoreboard bench driving a new-data and an old-data instance in lockstep
module tb_bist_sram_dp;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    bist_sram_dp_if b0 ();
    bist_sram_dp_if b1 ();
    assign b1.we       = b0.we;
    assign b1.waddr    = b0.waddr;
    assign b1.wdata    = b0.wdata;
    assign b1.re       = b0.re;
    assign b1.raddr    = b0.raddr;
    assign b1.flt_we   = b0.flt_we;
    assign b1.flt_idx  = b0.flt_idx;
    assign b1.flt_addr = b0.flt_addr;
    assign b1.flt_bit  = b0.flt_bit;
    assign b1.flt_type = b0.flt_type;
    assign b1.flt_en   = b0.flt_en;
    assign b1.flt_clr  = b0.flt_clr;
    bist_sram_dp #(.DATA_W(8), .ADDR_W(8), .RDW_MODE(0), .NUM_FLT(4)) u_new (.clk(clk), .rst(rst), .bus(b0));
    bist_sram_dp #(.DATA_W(8), .ADDR_W(8), .RDW_MODE(1), .NUM_FLT(4)) u_old (.clk(clk), .rst(rst), .bus(b1));
    int checks = 0;
    int errors = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic exp_v = 1'b0;
    logic mon_on = 1'b0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    always @(negedge clk)
        if (mon_on) begin
            check("rvalid_new", b0.rvalid, exp_v);
            check("rvalid_old", b1.rvalid, exp_v);
            if (exp_v && q0.size() != 0) begin
                check("rdata_new", b0.rdata, q0.pop_front());
                check("rdata_old", b1.rdata, q1.pop_front());
            end
        end
    task automatic cyc(input logic we, input logic [7:0] wa, input logic [7:0] wd,
                       input logic re, input logic [7:0] ra, input logic [7:0] e0, input logic [7:0] e1);
        b0.we = we;
        b0.waddr = wa;
        b0.wdata = wd;
        b0.re = re;
        b0.raddr = ra;
        if (re) begin
            q0.push_back(e0);
            q1.push_back(e1);
        end
        @(posedge clk);
        exp_v = re;
        #1;
        b0.we = 1'b0;
        b0.re = 1'b0;
        b0.flt_we = 1'b0;
        b0.flt_clr = 1'b0;
    endtask
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        cyc(1'b1, a, d, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask
    task automatic rd(input logic [7:0] a, input logic [7:0] e);
        cyc(1'b0, 8'h00, 8'h00, 1'b1, a, e, e);
    endtask
    task automatic idle();
        cyc(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask
    task automatic set_flt(input logic [1:0] idx, input logic [7:0] a, input logic [2:0] b,
                           input logic [1:0] t, input logic en);
        b0.flt_idx = idx;
        b0.flt_addr = a;
        b0.flt_bit = b;
        b0.flt_type = t;
        b0.flt_en = en;
        b0.flt_we = 1'b1;
    endtask
    initial begin
        b0.we = 0; b0.waddr = 0; b0.wdata = 0; b0.re = 0; b0.raddr = 0;
        b0.flt_we = 0; b0.flt_idx = 0; b0.flt_addr = 0; b0.flt_bit = 0;
        b0.flt_type = 0; b0.flt_en = 0; b0.flt_clr = 0;
        #1 rst = 1'b1;
        #2;
        check("rst_rdata_new", b0.rdata, 0);
        check("rst_rvalid_new", b0.rvalid, 0);
        check("rst_rdata_old", b1.rdata, 0);
        check("rst_rvalid_old", b1.rvalid, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 mon_on = 1'b1;
        // basic write / read back, idle cycle after
        wr(8'h10, 8'hA5);
        rd(8'h10, 8'hA5);
        idle();
        wr(8'h50, 8'h5A);
        // read-during-write, same and different address
        wr(8'h20, 8'h11);
        cyc(1'b1, 8'h20, 8'h22, 1'b1, 8'h20, 8'h22, 8'h11);
        rd(8'h20, 8'h22);
        cyc(1'b1, 8'h21, 8'h33, 1'b1, 8'h10, 8'hA5, 8'hA5);
        rd(8'h21, 8'h33);
        // stuck-at with priority
        set_flt(2'd0, 8'h30, 3'd3, 2'b01, 1'b1);
        idle();
        wr(8'h30, 8'h00);
        rd(8'h30, 8'h08);
        set_flt(2'd1, 8'h30, 3'd3, 2'b00, 1'b1);
        idle();
        rd(8'h30, 8'h00);
        wr(8'h30, 8'h08);
        rd(8'h30, 8'h00);
        // clear wins over a simultaneous entry write
        set_flt(2'd2, 8'h30, 3'd0, 2'b10, 1'b1);
        b0.flt_clr = 1'b1;
        idle();
        wr(8'h30, 8'h09);
        rd(8'h30, 8'h09);
        // transition faults
        set_flt(2'd0, 8'h40, 3'd0, 2'b10, 1'b1);
        idle();
        set_flt(2'd1, 8'h42, 3'd7, 2'b11, 1'b1);
        idle();
        wr(8'h40, 8'h00);
        wr(8'h40, 8'h01);
        rd(8'h40, 8'h00);
        wr(8'h41, 8'hFF);
        rd(8'h41, 8'hFF);
        wr(8'h42, 8'h80);
        wr(8'h42, 8'h00);
        rd(8'h42, 8'h80);
        cyc(1'b1, 8'h40, 8'h03, 1'b1, 8'h40, 8'h02, 8'h00);
        rd(8'h40, 8'h02);
        // fault written in the same cycle as the read applies one cycle later
        set_flt(2'd2, 8'h50, 3'd0, 2'b01, 1'b1);
        rd(8'h50, 8'h5A);
        rd(8'h50, 8'h5B);
        // asynchronous reset while a read is in flight
        b0.re = 1'b1;
        b0.raddr = 8'h50;
        @(posedge clk);
        #1 rst = 1'b1;
        exp_v = 1'b0;
        #1;
        check("arst_rdata_new", b0.rdata, 0);
        check("arst_rvalid_new", b0.rvalid, 0);
        check("arst_rdata_old", b1.rdata, 0);
        check("arst_rvalid_old", b1.rvalid, 0);
        b0.re = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        rd(8'h50, 8'h5A);
        idle();
        idle();
        check("queue_drained", q0.size(), 0);
        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bist_sram_dp.md
Name: bist_sram_dp

Overview:
- Parametrised simple-dual-port SRAM model: one write port, one read port, registered 1-cycle read, selectable read-during-write mode.
- Programmable fault-injection table (stuck-at-0, stuck-at-1, transition faults) so MBIST controllers and march algorithms can be exercised against known defects.
- Sits under the MBIST controller as the memory-under-test.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- ADDR_W, 8, address width; depth = 2**ADDR_W.
- RDW_MODE, 0, same-address read-during-write: 0 = return new (written) data, 1 = return old data.
- NUM_FLT, 4, number of fault-table entries (1..16).

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- re  in  1  read enable.
- raddr  in  ADDR_W  read address.
- rdata  out  DATA_W  registered read data.
- rvalid  out  1  high the cycle after an accepted read.
- flt_we  in  1  write one fault-table entry.
- flt_idx  in  clog2(NUM_FLT) (min 1)  entry index.
- flt_addr  in  ADDR_W  faulty cell address.
- flt_bit  in  clog2(DATA_W) (min 1)  faulty bit position.
- flt_type  in  2  00 SA0, 01 SA1, 10 TF-up (cell cannot go 0->1), 11 TF-down (cell cannot go 1->0).
- flt_en  in  1  enable bit stored into the entry.
- flt_clr  in  1  clear every entry's enable.

Behaviour:
- Reset (async assert): rdata=0, rvalid=0, all fault entries disabled, fields=0. Array contents are not reset and read X until written. Deassertion is synchronous to clk.
- Write (we=1): mem[waddr] <= wdata after the write-path fault rules.
- Write-path fault rules: for each enabled TF entry matching waddr, compare stored bit s and new bit n.
  - TF-up: if s=0 and n=1, the cell keeps 0.
  - TF-down: if s=1 and n=0, the cell keeps 1.
  - If s is X, the write completes normally.
- Read (re=1): rdata <= mem[raddr] after the read-path fault rules; rvalid <= 1.
  - Read latency is exactly 1 cycle.
  - With re=0: rvalid <= 0 and rdata holds its value.
- Read-path fault rules: each enabled SA0/SA1 entry matching raddr forces bit flt_bit of rdata to 0/1. SA faults are independent of whether the cell was ever written.
- Read-during-write, same address:
  - RDW_MODE=0: rdata = post-write-fault new value, then SA forcing.
  - RDW_MODE=1: rdata = the pre-write contents.
- Read-during-write, different addresses: the two ports are fully independent.
- Fault table is written at posedge on flt_we and affects accesses from the next cycle onward. An access in the same cycle as flt_we uses the old entry.
- flt_clr has priority over flt_we in the same cycle.
- Conflicting entries on the same address/bit: the highest-index enabled entry wins.
- flt_bit >= DATA_W: the entry is stored but never matches.
- Address wraps naturally; there is no out-of-range case.
- Reset mid-read: rvalid drops immediately and the pending read is discarded. Array contents survive reset.

Test Plan:
- Reset then write/read back: write 0xA5 to 0x10; re at 0x10 next cycle -> rdata=0xA5, rvalid=1 exactly one cycle later; rvalid=0 on idle cycles.
- RDW: RDW_MODE=0, mem[0x20]=0x11, write 0x22 with simultaneous read of 0x20 -> rdata=0x22. Repeat with RDW_MODE=1 -> 0x11.
- Stuck-at: entry0 = {addr 0x30, bit 3, SA1, en}. Write 0x00 to 0x30 -> read 0x08. Add entry1 SA0 on the same bit -> read 0x00 (higher index wins).
- Transition faults:
  - TF-up on 0x40 bit 0: write 0x00 then 0x01 -> read 0x00; write 0xFF to 0x41 -> read 0xFF.
  - TF-down on 0x42 bit 7: write 0x80 then 0x00 -> read 0x80.
- Table control: flt_clr and flt_we in the same cycle -> table empty; a faulted read in the same cycle as the flt_we enabling that fault -> unfaulted data, next read faulted.
- Async reset during an active read with mem[0x50]=0x5A -> rdata=0, rvalid=0 immediately; after release, read 0x50 -> 0x5A.
